// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player projectile pool with per-slot boxes and an RGB overlay.
// Optional BULLET_POOL_AUTOFIRE_EN: a held fire button re-requests a shot every frame.
module bullet_pool #(
    parameter int          NUM_BULLETS     = 4,
    parameter int          BULLET_W        = 4,
    parameter int          BULLET_H        = 12,
    parameter int          BULLET_SPEED    = 8,
    parameter int          COOLDOWN_FRAMES = 6,
    parameter int          VRES            = 480,
    parameter int          PADDLE_H        = 16,
    parameter int          SPAWN_Y         = VRES - PADDLE_H - BULLET_H,
    parameter logic [23:0] COLOR           = 24'hFFFF00
) (
    input  logic                          pixel_clk,
    input  logic                          rst_n,
    input  logic                          fsync,
    input  logic                          fire,
    input  logic [11:0]                   player_x,
    input  logic signed [11:0]            hpos,
    input  logic signed [11:0]            vpos,
    input  logic [NUM_BULLETS-1:0]        hit,
    output logic [0:2][7:0]               pixel,
    output logic [NUM_BULLETS-1:0]        bullet_active,
    output logic [12*NUM_BULLETS-1:0]     bullet_left,
    output logic [12*NUM_BULLETS-1:0]     bullet_right,
    output logic [12*NUM_BULLETS-1:0]     bullet_top,
    output logic [12*NUM_BULLETS-1:0]     bullet_bottom,
    output logic                          fire_dropped
);
    localparam int N = NUM_BULLETS;
    localparam logic signed [11:0] SPD = 12'(BULLET_SPEED);
    localparam logic signed [11:0] HW  = 12'(BULLET_W / 2);
    localparam logic signed [11:0] BH  = 12'(BULLET_H);
    localparam logic signed [11:0] SY  = 12'(SPAWN_Y);
    localparam logic [7:0]         CD  = 8'(COOLDOWN_FRAMES);

    logic [2:0]        sync;
    logic              fire_q;
    logic              fire_req;
    logic              manual;
    logic [7:0]        cooldown;
    logic signed [11:0] x [N];
    logic signed [11:0] y [N];
    logic [N-1:0]      active;
    logic [N-1:0]      free;
    logic [N-1:0]      sel;
    logic              rise;
    logic              try_fire;
    logic              spawn;
    logic              drop;
    logic              on;

    assign rise     = sync[2] & ~fire_q;
    assign free     = ~active;
    assign sel      = free & (~free + N'(1));
    // The counter expires on the same fsync that would allow the next spawn.
    assign try_fire = fsync & fire_req & (cooldown <= 8'd1);
    assign spawn    = try_fire & |free;
    assign drop     = try_fire & ~|free;

`ifdef BULLET_POOL_AUTOFIRE_EN
    logic req_auto;
    assign manual = ~req_auto;
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_req <= 1'b0;
            req_auto <= 1'b0;
        end else if (rise) begin
            fire_req <= 1'b1;
            req_auto <= 1'b0;
        end else if (fsync && sync[2] && (try_fire || !fire_req)) begin
            fire_req <= 1'b1;
            req_auto <= 1'b1;
        end else if (try_fire) begin
            fire_req <= 1'b0;
        end
    end
`else
    assign manual = 1'b1;
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n)        fire_req <= 1'b0;
        else if (rise)     fire_req <= 1'b1;
        else if (try_fire) fire_req <= 1'b0;
    end
`endif

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync         <= '0;
            fire_q       <= 1'b0;
            cooldown     <= '0;
            fire_dropped <= 1'b0;
            active       <= '0;
            for (int i = 0; i < N; i++) begin
                x[i] <= '0;
                y[i] <= '0;
            end
        end else begin
            sync         <= {sync[1:0], fire};
            fire_q       <= sync[2];
            fire_dropped <= drop & manual;
            if (fsync)
                cooldown <= spawn ? CD : (cooldown != 8'd0 ? cooldown - 8'd1 : 8'd0);
            for (int i = 0; i < N; i++) begin
                if (hit[i] && active[i]) begin
                    active[i] <= 1'b0;
                end else if (fsync) begin
                    if (active[i]) begin
                        if (y[i] > SPD) y[i] <= y[i] - SPD;
                        else            active[i] <= 1'b0;
                    end else if (spawn && sel[i]) begin
                        active[i] <= 1'b1;
                        x[i]      <= $signed(player_x);
                        y[i]      <= SY;
                    end
                end
            end
        end
    end

    assign bullet_active = active;
    for (genvar i = 0; i < N; i++) begin : g_box
        assign bullet_left[12*i+:12]   = x[i] - HW;
        assign bullet_right[12*i+:12]  = x[i] + HW;
        assign bullet_top[12*i+:12]    = y[i];
        assign bullet_bottom[12*i+:12] = y[i] + BH;
    end

    always_comb begin
        on = 1'b0;
        for (int i = 0; i < N; i++)
            if (active[i] && hpos >= x[i] - HW && hpos <= x[i] + HW &&
                vpos >= y[i] && vpos <= y[i] + BH)
                on = 1'b1;
        pixel[2] = on ? COLOR[23:16] : 8'd0;
        pixel[1] = on ? COLOR[15:8]  : 8'd0;
        pixel[0] = on ? COLOR[7:0]   : 8'd0;
    end
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed checks of spawn, cooldown, drop, retire, hit and raster drawing.
module tb_bullet_pool;
    logic              pixel_clk = 0;
    logic              rst_n = 0;
    logic              fsync = 0;
    logic              fire = 0;
    logic [11:0]       player_x = 12'd320;
    logic signed [11:0] hpos = 0;
    logic signed [11:0] vpos = 0;
    logic [3:0]        hit = 0;
    logic [0:2][7:0]   pixel;
    logic [3:0]        bullet_active;
    logic [47:0]       bullet_left, bullet_right, bullet_top, bullet_bottom;
    logic              fire_dropped;
    int                tests = 0;
    int                fails = 0;
    int                drops = 0;

    bullet_pool #(.SPAWN_Y(448)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .fire(fire),
        .player_x(player_x), .hpos(hpos), .vpos(vpos), .hit(hit),
        .pixel(pixel), .bullet_active(bullet_active),
        .bullet_left(bullet_left), .bullet_right(bullet_right),
        .bullet_top(bullet_top), .bullet_bottom(bullet_bottom),
        .fire_dropped(fire_dropped)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press();
        @(negedge pixel_clk) fire = 1;
        repeat (4) @(negedge pixel_clk);
        fire = 0;
        repeat (4) @(negedge pixel_clk);
    endtask

    task automatic frame(input logic [3:0] h);
        @(negedge pixel_clk);
        fsync = 1;
        hit = h;
        @(negedge pixel_clk);
        fsync = 0;
        hit = 0;
        drops += int'(fire_dropped);
        repeat (2) @(negedge pixel_clk);
    endtask

    initial begin
        repeat (3) @(negedge pixel_clk);
        check("rst_active", bullet_active, 4'b0000);
        check("rst_drop", fire_dropped, 1'b0);
        check("rst_pixel", pixel, 24'h0);
        check("rst_left", bullet_left, {4{12'hFFE}});
        check("rst_top", bullet_top, 48'h0);
        rst_n = 1;
        // F0: first spawn in slot0
        press();
        frame(4'b0000);
        check("spawn_active", bullet_active, 4'b0001);
        check("spawn_left", bullet_left[11:0], 12'd318);
        check("spawn_right", bullet_right[11:0], 12'd322);
        check("spawn_top", bullet_top[11:0], 12'd448);
        check("spawn_bottom", bullet_bottom[11:0], 12'd460);
        frame(4'b0000);
        check("move_top", bullet_top[11:0], 12'd440);
        // press before F2; cooldown holds it until F6
        press();
        frame(4'b0000);
        check("cd_f2", bullet_active, 4'b0001);
        repeat (3) frame(4'b0000);
        check("cd_f5", bullet_active, 4'b0001);
        frame(4'b0000);
        check("cd_f6_active", bullet_active, 4'b0011);
        check("cd_f6_top1", bullet_top[23:12], 12'd448);
        check("cd_f6_top0", bullet_top[11:0], 12'd400);
        // slots 2 and 3 at F12 and F18, then a dropped press at F24
        press();
        repeat (6) frame(4'b0000);
        check("fill_f12", bullet_active, 4'b0111);
        press();
        repeat (6) frame(4'b0000);
        check("fill_f18", bullet_active, 4'b1111);
        press();
        repeat (6) frame(4'b0000);
        check("drop_count", drops, 1);
        check("drop_active", bullet_active, 4'b1111);
        check("drop_top0", bullet_top[11:0], 12'd256);
        check("drop_top2", bullet_top[35:24], 12'd352);
        // F25: hit slot2 together with fsync
        frame(4'b0100);
        check("hit_active", bullet_active, 4'b1011);
        check("hit_top2", bullet_top[35:24], 12'd352);
        check("hit_top0", bullet_top[11:0], 12'd248);
        check("hit_top3", bullet_top[47:36], 12'd392);
        check("hit_top1", bullet_top[23:12], 12'd296);
        // F26..F55: slot0 reaches y=8
        repeat (30) frame(4'b0000);
        check("edge_top0", bullet_top[11:0], 12'd8);
        check("edge_active", bullet_active, 4'b1011);
        player_x = 12'd100;
        press();
        frame(4'b0000);
        check("retire_active", bullet_active, 4'b1110);
        check("retire_top2", bullet_top[35:24], 12'd448);
        check("retire_left2", bullet_left[35:24], 12'd98);
        check("retire_top1", bullet_top[23:12], 12'd48);
        check("drop_none", drops, 1);
        // raster over slot2 at x=100, y=448
        for (int v = 446; v <= 462; v++)
            for (int h = 96; h <= 104; h++) begin
                hpos = 12'(h);
                vpos = 12'(v);
                #1;
                check($sformatf("pix_%0d_%0d", h, v), {pixel[2], pixel[1], pixel[0]},
                      (h >= 98 && h <= 102 && v >= 448 && v <= 460) ? 24'hFFFF00 : 24'h0);
            end
        // asynchronous reset mid-flight
        @(posedge pixel_clk);
        #2 rst_n = 0;
        #1;
        check("midrst_active", bullet_active, 4'b0000);
        check("midrst_top", bullet_top, 48'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
